fft_iterative: RTL and testbench
================================

# fft_iterative

Sequential, memory-based radix-2 decimation-in-time FFT/IFFT. It is the resource-lean successor to the fully unrolled combinational FFT: one shared butterfly is reused across all stages, and data moves over valid/ready streams. Each frame of SIZE real samples is loaded, transformed in place over log2(SIZE) stages, then streamed out as complex bins. The block sits between a sample source (ADC/decimator) and spectral post-processing.

## Interface
- SIZE, 8: points per frame; power of two, 4..1024.
- IN_BITS, 16: signed input sample width.
- OUT_BITS, 24: signed width of output re/im and internal storage; must be >= IN_BITS.
- RESOLUTION, 8: fractional bits of twiddle coefficients.
- SCALE, 0: 1 = arithmetic right shift by 1 after every stage (result divided by SIZE); 0 = no scaling.
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a sample.
- in_data  input  IN_BITS  signed real sample, time order.
- inverse  input  1  0 = forward FFT, 1 = inverse (conjugate twiddles); sampled with the first sample of a frame.
- out_valid  output  1  out_re/out_im/out_last are valid.
- out_ready  input  1  downstream accepts a bin.
- out_re, out_im  output  OUT_BITS each  signed bin value, bin order 0..SIZE-1.
- out_last  output  1  high with bin SIZE-1.
- busy  output  1  high in COMPUTE.

## Operation
- States: LOAD -> COMPUTE -> UNLOAD -> LOAD. Reset state is LOAD.
- LOAD: in_ready=1. Each in_valid&&in_ready handshake sign-extends the sample to OUT_BITS. The sample is written to bit-reversed address rev(n) with im=0. n counts 0..SIZE-1. On the handshake with n=SIZE-1, go to COMPUTE.
- COMPUTE: stage s=0..LEVELS-1, butterfly index b=0..SIZE/2-1. One butterfly per cycle:
  - span h=2^s; group g=b>>s; k=b mod h; top=g*2h+k; bot=top+h.
  - Twiddle W=exp(-j*pi*k/h), or the conjugate when inverse=1.
  - Compute t=(B*W)>>>RESOLUTION, complex, with each re/im product arithmetic-shifted.
  - Write A'=A+t and B'=A-t, each then >>>1 if SCALE.
  - Read and write in the same cycle from the register array.
- After the last butterfly of the last stage, go to UNLOAD.
- Arithmetic: twiddle = round(cos,sin * 2^RESOLUTION), stored in RESOLUTION+2 signed bits. Products use full width before the shift. Sums are truncated to OUT_BITS with two's-complement wrap; there is no saturation.
- UNLOAD: out_valid=1; bins presented at address 0..SIZE-1. On out_valid&&!out_ready, all outputs are held stable. The handshake on bin SIZE-1 (out_last=1) returns to LOAD.
- in_ready=0 outside LOAD. Input is never accepted during COMPUTE or UNLOAD, and no overlap between frames is permitted.
- Reset asserted mid-frame: the partial frame is discarded and the block returns to LOAD with counters at 0. Memory contents are don't-care.

## Timing
- Reset values: in_ready=1, out_valid=0, out_re=0, out_im=0, out_last=0, busy=0.
- LOAD takes SIZE accepted handshakes. Gaps on in_valid are allowed.
- COMPUTE takes exactly LEVELS*SIZE/2 cycles, with busy high throughout.
- First out_valid occurs the cycle after the final COMPUTE cycle.
- Latency: with continuous handshakes, last input handshake to first output is LEVELS*SIZE/2+1 cycles. For SIZE=8 that is 13.
- Frame period with no stalls: SIZE + LEVELS*SIZE/2 + SIZE cycles. For SIZE=8 that is 28.
- in_ready rises in the cycle after the final output handshake.

## Structure
- Package fft_pkg:
  - state enum (LOAD, COMPUTE, UNLOAD);
  - bit_reverse function;
  - twiddle ROM generator function parameterised by SIZE and RESOLUTION, evaluated at elaboration.
- Sub-module fft_butterfly: combinational complex butterfly (A, B, W_re, W_im, scale) -> (A', B'), parameterised by OUT_BITS and RESOLUTION.
- Top level: control FSM, counters, address generation, storage.

## Test plan
- Impulse (SIZE=8, IN_BITS=16, OUT_BITS=24, RESOLUTION=8, SCALE=0): in = [100,0,0,0,0,0,0,0] -> every bin re=100, im=0; out_last only on bin 7.
- DC: in = all 1 -> bin0 re=8, im=0; bins 1..7 = 0.
- Tone: in = [0,64,0,-64,0,64,0,-64] -> bin2 = (0,-256), bin6 = (0,+256), all other bins 0.
  - Same frame with inverse=1 -> bin2 = (0,+256), bin6 = (0,-256).
  - Same frame with SCALE=1 -> bin2 im=-32.
- Backpressure: out_ready toggles 1,0,0,1 during UNLOAD -> outputs stable while stalled; exactly 8 handshakes; in_ready=0 until the final one. Measured latency is 13 cycles.
- Reset after 5 of 8 samples loaded -> in_ready=1, out_valid=0. A following full impulse frame yields all-100 bins.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the iterative radix-2 FFT.
// Twiddles come from an integer Taylor series so no real-valued math reaches synthesis.
package fft_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } fft_state_e;

  localparam int     FX_FRAC      = 32'sd28;
  localparam longint FX_ONE       = 64'sd268435456;
  localparam longint FX_PI        = 64'sd843314857;
  localparam int     TAYLOR_TERMS = 32'sd14;

  function automatic logic [15:0] bit_reverse(input logic [15:0] v, input int bits);
    logic [15:0] r;
    r = 16'd0;
    for (int i = 0; i < 16; i++) begin
      if (i < bits) begin
        r[bits-1-i] = v[i];
      end
    end
    return r;
  endfunction

  // round(cos or sin of 2*pi*idx/size, scaled by 2^res); angle is always in [0, pi)
  function automatic int twiddle(input int idx, input int size, input int res, input logic want_sin);
    longint x, x2, term, acc, div;
    x    = (FX_PI * 64'(idx) * 64'sd2) / 64'(size);
    x2   = (x * x) >>> FX_FRAC;
    term = want_sin ? x : FX_ONE;
    acc  = term;
    for (int i = 1; i <= TAYLOR_TERMS; i++) begin
      div  = want_sin ? 64'(32'sd2 * i * (32'sd2 * i + 32'sd1))
                      : 64'(32'sd2 * i * (32'sd2 * i - 32'sd1));
      term = -(((term * x2) >>> FX_FRAC) / div);
      acc  = acc + term;
    end
    return int'((acc + (FX_ONE >>> (res + 32'sd1))) >>> (FX_FRAC - res));
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Combinational radix-2 DIT butterfly: A' = A + B*W, B' = A - B*W, optional halving.
module fft_butterfly
  import fft_pkg::*;
#(
  parameter int OUT_BITS   = 24,
  parameter int RESOLUTION = 8
) (
  input  logic signed [OUT_BITS-1:0]   a_re_i,
  input  logic signed [OUT_BITS-1:0]   a_im_i,
  input  logic signed [OUT_BITS-1:0]   b_re_i,
  input  logic signed [OUT_BITS-1:0]   b_im_i,
  input  logic signed [RESOLUTION+1:0] w_re_i,
  input  logic signed [RESOLUTION+1:0] w_im_i,
  input  logic                         scale_i,
  output logic signed [OUT_BITS-1:0]   a_re_o,
  output logic signed [OUT_BITS-1:0]   a_im_o,
  output logic signed [OUT_BITS-1:0]   b_re_o,
  output logic signed [OUT_BITS-1:0]   b_im_o
);
  localparam int TW = RESOLUTION + 2;
  localparam int PW = OUT_BITS + TW;
  localparam int SW = OUT_BITS + 1;

  logic signed [PW-1:0]       p_rr_s, p_ii_s, p_ri_s, p_ir_s, t_re_full_s, t_im_full_s;
  logic signed [OUT_BITS-1:0] t_re_s, t_im_s;
  logic signed [SW-1:0]       sum_re_s, sum_im_s, dif_re_s, dif_im_s;

  // Each partial product is shifted on its own before combining, one guard bit kept for halving
  always_comb begin
    p_rr_s      = PW'(b_re_i) * PW'(w_re_i);
    p_ii_s      = PW'(b_im_i) * PW'(w_im_i);
    p_ri_s      = PW'(b_re_i) * PW'(w_im_i);
    p_ir_s      = PW'(b_im_i) * PW'(w_re_i);
    t_re_full_s = (p_rr_s >>> RESOLUTION) - (p_ii_s >>> RESOLUTION);
    t_im_full_s = (p_ri_s >>> RESOLUTION) + (p_ir_s >>> RESOLUTION);
    t_re_s      = OUT_BITS'(t_re_full_s);
    t_im_s      = OUT_BITS'(t_im_full_s);
    sum_re_s    = SW'(a_re_i) + SW'(t_re_s);
    sum_im_s    = SW'(a_im_i) + SW'(t_im_s);
    dif_re_s    = SW'(a_re_i) - SW'(t_re_s);
    dif_im_s    = SW'(a_im_i) - SW'(t_im_s);
    if (scale_i) begin
      a_re_o = OUT_BITS'(sum_re_s >>> 1'b1);
      a_im_o = OUT_BITS'(sum_im_s >>> 1'b1);
      b_re_o = OUT_BITS'(dif_re_s >>> 1'b1);
      b_im_o = OUT_BITS'(dif_im_s >>> 1'b1);
    end else begin
      a_re_o = OUT_BITS'(sum_re_s);
      a_im_o = OUT_BITS'(sum_im_s);
      b_re_o = OUT_BITS'(dif_re_s);
      b_im_o = OUT_BITS'(dif_im_s);
    end
  end

endmodule

// File: rtl/fft_iterative.sv
// In-place radix-2 DIT FFT/IFFT with one shared butterfly: load in bit-reversed order,
// run LEVELS stages of SIZE/2 butterflies, then stream bins out over valid/ready.
module fft_iterative
  import fft_pkg::*;
#(
  parameter int SIZE       = 8,
  parameter int IN_BITS    = 16,
  parameter int OUT_BITS   = 24,
  parameter int RESOLUTION = 8,
  parameter int SCALE      = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [IN_BITS-1:0]  in_data,
  input  logic                       inverse,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_BITS-1:0] out_re,
  output logic signed [OUT_BITS-1:0] out_im,
  output logic                       out_last,
  output logic                       busy
);
  localparam int LEVELS = $clog2(SIZE);
  localparam int AW     = LEVELS;
  localparam int BW     = LEVELS - 1;
  localparam int SW     = (LEVELS > 2) ? $clog2(LEVELS) : 1;
  localparam int TW     = RESOLUTION + 2;
  localparam logic [AW-1:0] LAST_N = AW'(SIZE - 1);
  localparam logic [BW-1:0] LAST_B = BW'(SIZE / 2 - 1);
  localparam logic [SW-1:0] LAST_S = SW'(LEVELS - 1);

  fft_state_e                 state_q, state_d;
  logic [AW-1:0]              n_q, n_d, n_inc_s;
  logic [SW-1:0]              stage_q, stage_d;
  logic [BW-1:0]              bfly_q, bfly_d;
  logic                       inv_q, inv_d;
  logic                       in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic                       out_last_q, out_last_d, busy_q, busy_d;
  logic signed [OUT_BITS-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic                       load_we_s, bfly_we_s;

  logic signed [OUT_BITS-1:0] mem_re_q [SIZE];
  logic signed [OUT_BITS-1:0] mem_im_q [SIZE];
  logic signed [TW-1:0]       tw_cos [SIZE/2];
  logic signed [TW-1:0]       tw_sin [SIZE/2];

  for (genvar i = 0; i < SIZE / 2; i++) begin : g_twiddle
    localparam int COS_V = twiddle(i, SIZE, RESOLUTION, 1'b0);
    localparam int SIN_V = twiddle(i, SIZE, RESOLUTION, 1'b1);
    assign tw_cos[i] = TW'(COS_V);
    assign tw_sin[i] = TW'(SIN_V);
  end

  logic [AW-1:0]              bfly_ext_s, span_s, k_s, top_s, bot_s, rev_s;
  logic [BW-1:0]              tw_idx_s;
  logic signed [TW-1:0]       w_re_s, w_im_s;
  logic signed [OUT_BITS-1:0] a_re_s, a_im_s, b_re_s, b_im_s;

  // Butterfly addressing; twiddle index k*(SIZE/2h) maps every stage onto one ROM
  always_comb begin
    bfly_ext_s = AW'(bfly_q);
    span_s     = AW'(1) << stage_q;
    k_s        = bfly_ext_s & (span_s - AW'(1));
    top_s      = (((bfly_ext_s >> stage_q) << 1'b1) << stage_q) | k_s;
    bot_s      = top_s | span_s;
    tw_idx_s   = BW'(k_s << (LAST_S - stage_q));
    rev_s      = AW'(bit_reverse(16'(n_q), AW));
    w_re_s     = tw_cos[tw_idx_s];
    w_im_s     = inv_q ? tw_sin[tw_idx_s] : -tw_sin[tw_idx_s];
  end

  fft_butterfly #(
    .OUT_BITS   (OUT_BITS),
    .RESOLUTION (RESOLUTION)
  ) u_butterfly (
    .a_re_i  (mem_re_q[top_s]),
    .a_im_i  (mem_im_q[top_s]),
    .b_re_i  (mem_re_q[bot_s]),
    .b_im_i  (mem_im_q[bot_s]),
    .w_re_i  (w_re_s),
    .w_im_i  (w_im_s),
    .scale_i (SCALE != 32'sd0),
    .a_re_o  (a_re_s),
    .a_im_o  (a_im_s),
    .b_re_o  (b_re_s),
    .b_im_o  (b_im_s)
  );

  // Control FSM, counters and the next registered output values
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    stage_d    = stage_q;
    bfly_d     = bfly_q;
    inv_d      = inv_q;
    out_re_d   = out_re_q;
    out_im_d   = out_im_q;
    out_last_d = out_last_q;
    load_we_s  = 1'b0;
    bfly_we_s  = 1'b0;
    n_inc_s    = n_q + AW'(1);
    case (state_q)
      LOAD: begin
        if (in_valid && in_ready_q) begin
          load_we_s = 1'b1;
          n_d       = n_inc_s;
          if (n_q == '0) inv_d = inverse;
          else           inv_d = inv_q;
          if (n_q == LAST_N) state_d = COMPUTE;
          else               state_d = LOAD;
        end else begin
          state_d = LOAD;
        end
      end
      COMPUTE: begin
        bfly_we_s = 1'b1;
        bfly_d    = bfly_q + BW'(1);
        if (bfly_q == LAST_B) begin
          if (stage_q == LAST_S) begin
            stage_d    = '0;
            state_d    = UNLOAD;
            out_re_d   = mem_re_q[0];
            out_im_d   = mem_im_q[0];
            out_last_d = 1'b0;
          end else begin
            stage_d = stage_q + SW'(1);
          end
        end else begin
          stage_d = stage_q;
        end
      end
      UNLOAD: begin
        if (out_valid_q && out_ready) begin
          n_d = n_inc_s;
          if (n_q == LAST_N) begin
            state_d    = LOAD;
            out_last_d = 1'b0;
          end else begin
            out_re_d   = mem_re_q[n_inc_s];
            out_im_d   = mem_im_q[n_inc_s];
            out_last_d = (n_inc_s == LAST_N);
          end
        end else begin
          n_d = n_q;
        end
      end
      default: state_d = LOAD;
    endcase
    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == UNLOAD);
    busy_d      = (state_d == COMPUTE);
  end

  // State, counters and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      n_q         <= '0;
      stage_q     <= '0;
      bfly_q      <= '0;
      inv_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      stage_q     <= stage_d;
      bfly_q      <= bfly_d;
      inv_q       <= inv_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  // Sample store; contents after reset are don't-care so it has no reset
  always_ff @(posedge clk) begin
    if (load_we_s) begin
      mem_re_q[rev_s] <= OUT_BITS'(in_data);
      mem_im_q[rev_s] <= '0;
    end else if (bfly_we_s) begin
      mem_re_q[top_s] <= a_re_s;
      mem_im_q[top_s] <= a_im_s;
      mem_re_q[bot_s] <= b_re_s;
      mem_im_q[bot_s] <= b_im_s;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fft_iterative.sv
// Bench for fft_iterative: unscaled and scaled instances run in lockstep against a
// floating-point-twiddle reference of the radix-2 algorithm.
module tb_fft_iterative;
  localparam int  SIZE     = 8;
  localparam int  LEVELS   = 3;
  localparam int  IN_BITS  = 16;
  localparam int  OUT_BITS = 24;
  localparam int  RES      = 8;
  localparam real PI       = 3.14159265358979;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic signed [IN_BITS-1:0] in_data = '0;
  logic inverse = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_last, busy;
  logic signed [OUT_BITS-1:0] out_re, out_im;
  logic in_ready_s, out_valid_s, out_last_s, busy_s;
  logic signed [OUT_BITS-1:0] out_re_s, out_im_s;

  int total = 0;
  int bad = 0;
  int samp [SIZE];
  longint exp_re [2][SIZE];
  longint exp_im [2][SIZE];
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  fft_iterative #(.SIZE(SIZE), .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .RESOLUTION(RES), .SCALE(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .inverse(inverse), .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re),
    .out_im(out_im), .out_last(out_last), .busy(busy));

  fft_iterative #(.SIZE(SIZE), .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .RESOLUTION(RES), .SCALE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .inverse(inverse), .out_valid(out_valid_s), .out_ready(out_ready), .out_re(out_re_s),
    .out_im(out_im_s), .out_last(out_last_s), .busy(busy_s));

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
    end
  endtask

  function automatic longint rnd(input real x);
    if (x >= 0.0) return longint'($rtoi(x + 0.5));
    else          return longint'($rtoi(x - 0.5));
  endfunction

  function automatic longint wrap(input longint v);
    return (v <<< 40) >>> 40;
  endfunction

  // Reference: bit-reversed load, then log2(SIZE) stages of in-place butterflies
  task automatic model(input bit inv, input int sc);
    longint re [SIZE];
    longint im [SIZE];
    longint wr, wi, tr, ti, ar, ai, br, bi;
    int rv, h, k, top, bot;
    real ang;
    for (int n = 0; n < SIZE; n++) begin
      rv = 0;
      for (int b = 0; b < LEVELS; b++) if (((n >> b) & 1) != 0) rv += 1 << (LEVELS - 1 - b);
      re[rv] = samp[n];
      im[rv] = 0;
    end
    for (int s = 0; s < LEVELS; s++) begin
      h = 1 << s;
      for (int b = 0; b < SIZE / 2; b++) begin
        k   = b % h;
        top = (b / h) * 2 * h + k;
        bot = top + h;
        ang = PI * k / h;
        wr  = rnd($cos(ang) * (1 << RES));
        wi  = rnd(-$sin(ang) * (1 << RES));
        if (inv) wi = -wi;
        tr = ((re[bot] * wr) >>> RES) - ((im[bot] * wi) >>> RES);
        ti = ((re[bot] * wi) >>> RES) + ((im[bot] * wr) >>> RES);
        ar = re[top] + tr; ai = im[top] + ti;
        br = re[top] - tr; bi = im[top] - ti;
        if (sc != 0) begin
          ar = ar >>> 1; ai = ai >>> 1; br = br >>> 1; bi = bi >>> 1;
        end
        re[top] = wrap(ar); im[top] = wrap(ai);
        re[bot] = wrap(br); im[bot] = wrap(bi);
      end
    end
    for (int n = 0; n < SIZE; n++) begin
      exp_re[sc][n] = re[n];
      exp_im[sc][n] = im[n];
    end
  endtask

  task automatic run_frame(input bit inv, input bit stall, input bit gaps);
    int n, guard, lat, bin, i;
    bit held;
    longint hre, him;
    logic hlast;
    model(inv, 0);
    model(inv, 1);
    n = 0; guard = 0;
    while (n < SIZE && guard < 400) begin
      @(negedge clk); guard++;
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = IN_BITS'(samp[n]);
      inverse  = (n == 0) ? inv : 1'($urandom_range(0, 1));
      if (in_valid && in_ready) n++;
    end
    check("load_count", n, SIZE);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    check("busy_compute", busy, 1);
    check("in_ready_compute", in_ready, 0);
    while (!out_valid && lat < 200) begin
      @(negedge clk); lat++;
    end
    check("latency", lat, 13);
    check("busy_unload", busy, 0);
    bin = 0; i = 0; held = 1'b0; guard = 0;
    while (bin < SIZE && guard < 400) begin
      guard++;
      if (held) begin
        check("hold_re", out_re, hre);
        check("hold_im", out_im, him);
        check("hold_last", out_last, hlast);
      end
      out_ready = stall ? pat[i % 4] : 1'b1;
      i++;
      if (out_valid && out_ready) begin
        check($sformatf("re[%0d]", bin), out_re, exp_re[0][bin]);
        check($sformatf("im[%0d]", bin), out_im, exp_im[0][bin]);
        check($sformatf("last[%0d]", bin), out_last, (bin == SIZE - 1));
        check($sformatf("scaled_re[%0d]", bin), out_re_s, exp_re[1][bin]);
        check($sformatf("scaled_im[%0d]", bin), out_im_s, exp_im[1][bin]);
        check($sformatf("in_ready_unload[%0d]", bin), in_ready, 0);
        bin++;
        held = 1'b0;
      end else if (out_valid) begin
        held = 1'b1; hre = out_re; him = out_im; hlast = out_last;
      end else begin
        check("out_valid_unload", out_valid, 1);
        held = 1'b0;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("in_ready_after", in_ready, 1);
    check("out_valid_after", out_valid, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_re", out_re, 0);
    check("rst_out_im", out_im, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);

    for (int n = 0; n < SIZE; n++) samp[n] = (n == 0) ? 100 : 0;
    run_frame(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < SIZE; n++) samp[n] = 1;
    run_frame(1'b0, 1'b0, 1'b1);
    samp = '{0, 64, 0, -64, 0, 64, 0, -64};
    run_frame(1'b0, 1'b0, 1'b0);
    run_frame(1'b1, 1'b0, 1'b0);
    run_frame(1'b0, 1'b1, 1'b0);

    // Abort a frame after five samples
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = IN_BITS'(n + 7);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    for (int n = 0; n < SIZE; n++) samp[n] = (n == 0) ? 100 : 0;
    run_frame(1'b0, 1'b0, 1'b0);

    for (int f = 0; f < 6; f++) begin
      for (int n = 0; n < SIZE; n++) samp[n] = int'($urandom_range(0, 65535)) - 32768;
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
